// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I-subset core: one ALU and one req/ready memory port shared
// across FETCH/DECODE/EXEC/MEM/WB, with illegal/misaligned trap and retire counter.
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             areset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             WE,
  output logic [31:0]      data_out,
  output logic             trap,
  output logic [CNT_W-1:0] retire_count
);
  localparam int unsigned AW = (REG_COUNT == 16) ? 4 : 5;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_old, ir, a, b, alu_out, mdr;
  logic [31:0] regs [REG_COUNT];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        is_lw, is_sw, is_opimm, is_op, is_br, is_jal;
  logic        uses_rs1, uses_rs2, uses_rd, legal;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm, op_b, alu_res;
  logic [31:0] br_target, jal_target;
  logic        taken, retire;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign is_lw    = (opcode == 7'b0000011);
  assign is_sw    = (opcode == 7'b0100011);
  assign is_opimm = (opcode == 7'b0010011);
  assign is_op    = (opcode == 7'b0110011);
  assign is_br    = (opcode == 7'b1100011);
  assign is_jal   = (opcode == 7'b1101111);

  assign uses_rs1 = is_lw | is_sw | is_opimm | is_op | is_br;
  assign uses_rs2 = is_sw | is_op | is_br;
  assign uses_rd  = is_lw | is_opimm | is_op | is_jal;

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  always_comb begin
    legal = 1'b0;
    case (opcode)
      7'b0000011: legal = (funct3 == 3'b010);
      7'b0100011: legal = (funct3 == 3'b010);
      7'b0010011: legal = funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
      7'b0110011: legal = ((funct7 == 7'b0000000) && (funct3 inside {3'b000, 3'b010, 3'b110, 3'b111}))
                       || ((funct7 == 7'b0100000) && (funct3 == 3'b000));
      7'b1100011: legal = funct3 inside {3'b000, 3'b001, 3'b100};
      7'b1101111: legal = 1'b1;
      default:    legal = 1'b0;
    endcase
    // RV32E: only register fields actually used by the format are checked
    if (REG_COUNT == 16) begin
      if ((uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]) || (uses_rd && rd[4]))
        legal = 1'b0;
    end
  end

  always_comb begin
    imm     = is_sw ? imm_s : imm_i;
    op_b    = is_op ? b : imm;
    alu_res = a + op_b;
    if (is_jal) begin
      alu_res = pc_old + 32'd4;
    end else if (is_op || is_opimm) begin
      case (funct3)
        3'b111:  alu_res = a & op_b;
        3'b110:  alu_res = a | op_b;
        3'b010:  alu_res = {31'b0, $signed(a) < $signed(op_b)};
        default: alu_res = (is_op && funct7[5]) ? a - op_b : a + op_b;
      endcase
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) < $signed(b));
      default: taken = 1'b0;
    endcase
  end

  assign br_target  = pc_old + imm_b;
  assign jal_target = pc_old + imm_j;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_lw || is_sw)
          state_next = (alu_res[1:0] == 2'b00) ? S_MEM : S_TRAP;
        else if (is_br)
          state_next = (taken && (br_target[1:0] != 2'b00)) ? S_TRAP : S_FETCH;
        else if (is_jal)
          state_next = (jal_target[1:0] != 2'b00) ? S_TRAP : S_WB;
        else
          state_next = S_WB;
      end
      S_MEM:    if (mem_ready) state_next = is_lw ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_TRAP;
    endcase
  end

  assign retire = (state == S_WB)
               || ((state == S_EXEC) && is_br && (state_next == S_FETCH))
               || ((state == S_MEM) && is_sw && mem_ready);

  // Request gated by areset so it drops in the same cycle reset is raised
  assign mem_req   = !areset && ((state == S_FETCH) || (state == S_MEM));
  assign mem_we    = (state == S_MEM) && is_sw;
  assign mem_addr  = (state == S_MEM) ? alu_out : pc;
  assign mem_wdata = b;
  assign WE        = mem_req & mem_we;
  assign data_out  = mem_wdata;
  assign trap      = (state == S_TRAP);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pc           <= RESET_PC;
      pc_old       <= RESET_PC;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      alu_out      <= '0;
      mdr          <= '0;
      retire_count <= '0;
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i[AW-1:0]] <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir     <= mem_rdata;
          pc_old <= pc;
        end
        S_DECODE: begin
          a <= regs[rs1[AW-1:0]];
          b <= regs[rs2[AW-1:0]];
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (is_br && (state_next == S_FETCH)) pc <= taken ? br_target : pc_old + 32'd4;
          if (is_jal && (state_next == S_WB))   pc <= jal_target;
        end
        S_MEM: if (mem_ready) begin
          if (is_lw) mdr <= mem_rdata;
          else       pc  <= pc_old + 32'd4;
        end
        S_WB: begin
          if (rd[AW-1:0] != '0) regs[rd[AW-1:0]] <= is_lw ? mdr : alu_out;
          if (!is_jal) pc <= pc_old + 32'd4;
        end
        default: ;
      endcase
      if (retire) retire_count <= retire_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed-vector bench for riscv_multicycle_core: small programs run against a
// wait-state memory model, results observed through stores, latency and status ports.
module tb_riscv_multicycle_core;
  logic        clk = 1'b0;
  logic        areset;
  logic        mem_req, mem_we, mem_ready, WE, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, data_out, retire_count;

  logic        e_rst, e_req, e_we, e_ready, e_WE, e_trap;
  logic [31:0] e_addr, e_wdata, e_rdata, e_data, e_retire;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [64];
  int unsigned waits = 0;
  int unsigned wcnt;

  always #5 clk = ~clk;

  riscv_multicycle_core #(.RESET_PC(32'h0), .REG_COUNT(32), .CNT_W(32)) dut (
    .clk(clk), .areset(areset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .WE(WE),
    .data_out(data_out), .trap(trap), .retire_count(retire_count)
  );

  riscv_multicycle_core #(.RESET_PC(32'h100), .REG_COUNT(16), .CNT_W(32)) dut_e (
    .clk(clk), .areset(e_rst), .mem_req(e_req), .mem_we(e_we), .mem_addr(e_addr),
    .mem_wdata(e_wdata), .mem_rdata(e_rdata), .mem_ready(e_ready), .WE(e_WE),
    .data_out(e_data), .trap(e_trap), .retire_count(e_retire)
  );

  // Memory answers after `waits` stalled cycles per request
  assign mem_ready = mem_req && (wcnt >= waits);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      wcnt <= 0;
    end else if (mem_req && mem_ready) begin
      wcnt <= 0;
      if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int op, input int f3, input int rd, input int rs1, input int imm);
    logic [31:0] o, f, d, s, m;
    o = op; f = f3; d = rd; s = rs1; m = imm;
    return {m[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] g, t, s, f, d;
    g = f7; t = rs2; s = rs1; f = f3; d = rd;
    return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
    logic [31:0] t, s, m;
    t = rs2; s = rs1; m = imm;
    return {m[11:5], t[4:0], s[4:0], 3'b010, m[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
    logic [31:0] f, s, t, m;
    f = f3; s = rs1; t = rs2; m = imm;
    return {m[12], m[10:5], t[4:0], s[4:0], f[2:0], m[4:1], m[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int rd, input int imm);
    logic [31:0] d, m;
    d = rd; m = imm;
    return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'b1101111};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    logic [31:0] a;
    a = addr;
    mem[a[7:2]] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i[5:0]] = (i >= 32) ? 32'hDEAD_BEEF : 32'h0;
  endtask

  task automatic do_reset(input string tag, input int unsigned w);
    areset = 1'b1;
    @(negedge clk); #1;
    check({tag, "_rst_req"}, 32'(mem_req), 32'h0);
    check({tag, "_rst_trap"}, 32'(trap), 32'h0);
    check({tag, "_rst_retire"}, retire_count, 32'h0);
    waits = w;
    @(negedge clk);
    areset = 1'b0;
    #1;
    check({tag, "_first_req"}, 32'(mem_req), 32'h1);
    check({tag, "_first_addr"}, mem_addr, 32'h0);
  endtask

  task automatic wait_fetch(input logic [31:0] addr, input int budget, output int cycles);
    cycles = 0;
    while (!(mem_req && !mem_we && mem_addr == addr) && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic wait_trap(input string tag, input int budget);
    int n;
    n = 0;
    while (!trap && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_trap"}, 32'(trap), 32'h1);
  endtask

  initial begin
    int n;
    areset  = 1'b1;
    e_rst   = 1'b1;
    e_ready = 1'b1;
    e_rdata = 32'h0;

    // Program A: arithmetic, wait-state store/load, branches, illegal opcode
    clear_mem();
    put(32'h00, enc_i(7'h13, 0, 1, 0, 5));
    put(32'h04, enc_i(7'h13, 0, 2, 0, -3));
    put(32'h08, enc_r(0, 2, 1, 0, 3));
    put(32'h0C, enc_s(3, 0, 8));
    put(32'h10, enc_i(7'h03, 2, 4, 0, 8));
    put(32'h14, enc_s(4, 0, 32'h84));
    put(32'h18, enc_b(4, 2, 1, 8));
    put(32'h1C, enc_i(7'h13, 0, 5, 0, 1));
    put(32'h20, enc_b(1, 0, 0, 8));
    put(32'h24, enc_r(7'h20, 2, 1, 0, 6));
    put(32'h28, enc_r(0, 1, 2, 2, 7));
    put(32'h2C, enc_s(5, 0, 32'h88));
    put(32'h30, enc_s(6, 0, 32'h8C));
    put(32'h34, enc_s(7, 0, 32'h90));
    put(32'h38, 32'h0000_007F);
    do_reset("a", 0);
    repeat (12) @(negedge clk);
    check("a_retire12", retire_count, 32'd3);
    check("a_fetch_c", mem_addr, 32'hC);
    waits = 2;
    n = 0;
    while (!WE && n < 40) begin @(negedge clk); n++; end
    check("sw_we_seen", 32'(WE), 32'h1);
    check("sw_addr", mem_addr, 32'h8);
    check("sw_data", data_out, 32'h2);
    n = 0;
    while (WE && n < 10) begin @(negedge clk); n++; end
    check("sw_we_len", n, 32'd3);
    wait_fetch(32'h18, 60, n);
    waits = 0;
    wait_fetch(32'h20, 10, n);
    check("blt_taken_lat", n, 32'd3);
    wait_fetch(32'h24, 10, n);
    check("bne_nt_lat", n, 32'd3);
    wait_trap("a", 100);
    check("a_mem_sw8", mem[2], 32'h2);
    check("a_lw_x4", mem[33], 32'h2);
    check("a_skip_x5", mem[34], 32'h0);
    check("a_sub_x6", mem[35], 32'h8);
    check("a_slt_x7", mem[36], 32'h1);
    check("a_retire", retire_count, 32'd13);
    repeat (5) @(negedge clk);
    check("a_trap_req", 32'(mem_req), 32'h0);
    check("a_trap_sticky", 32'(trap), 32'h1);
    check("a_retire_frozen", retire_count, 32'd13);

    // Program B: logic immediates, jal, x0 write, misaligned load
    clear_mem();
    put(32'h00, enc_i(7'h13, 0, 1, 0, -6));
    put(32'h04, enc_i(7'h13, 7, 2, 1, 15));
    put(32'h08, enc_i(7'h13, 6, 3, 2, 32'h50));
    put(32'h0C, enc_i(7'h13, 2, 4, 1, -5));
    put(32'h10, enc_b(1, 8, 0, 32'h18));
    put(32'h14, enc_r(0, 4, 3, 6, 5));
    put(32'h18, enc_b(0, 4, 0, 8));
    put(32'h1C, enc_i(7'h13, 0, 8, 0, 1));
    put(32'h20, enc_j(1, -16));
    put(32'h24, enc_i(7'h13, 0, 9, 0, 1));
    put(32'h28, enc_b(0, 2, 2, 8));
    put(32'h2C, enc_i(7'h13, 0, 9, 0, 2));
    put(32'h30, enc_i(7'h13, 0, 0, 0, 7));
    put(32'h34, enc_s(0, 0, 32'h80));
    put(32'h38, enc_s(1, 0, 32'h84));
    put(32'h3C, enc_s(5, 0, 32'h88));
    put(32'h40, enc_s(9, 0, 32'h8C));
    put(32'h44, enc_s(4, 0, 32'h90));
    put(32'h48, enc_r(0, 2, 3, 7, 6));
    put(32'h4C, enc_s(6, 0, 32'h94));
    put(32'h50, enc_i(7'h03, 2, 10, 0, 6));
    do_reset("b", 0);
    wait_fetch(32'h20, 60, n);
    wait_fetch(32'h10, 10, n);
    check("jal_lat", n, 32'd4);
    wait_fetch(32'h28, 10, n);
    check("bne_taken_lat", n, 32'd3);
    wait_fetch(32'h30, 10, n);
    check("beq_taken_lat", n, 32'd3);
    wait_trap("b", 100);
    check("b_x0", mem[32], 32'h0);
    check("b_jal_link", mem[33], 32'h24);
    check("b_or", mem[34], 32'h5B);
    check("b_skip_x9", mem[35], 32'h0);
    check("b_slti", mem[36], 32'h1);
    check("b_and", mem[37], 32'hA);
    check("b_retire", retire_count, 32'd19);
    check("b_trap_req", 32'(mem_req), 32'h0);

    // Program C: reset raised while a store is waiting in MEM
    clear_mem();
    put(32'h00, enc_s(0, 0, 32'h80));
    do_reset("c", 3);
    n = 0;
    while (!WE && n < 20) begin @(negedge clk); n++; end
    check("c_we_seen", 32'(WE), 32'h1);
    #2 areset = 1'b1;
    #1;
    check("c_req_drop", 32'(mem_req), 32'h0);
    check("c_we_drop", 32'(WE), 32'h0);
    @(negedge clk);
    waits = 0;
    areset = 1'b0;
    #1;
    check("c_restart_req", 32'(mem_req), 32'h1);
    check("c_restart_addr", mem_addr, 32'h0);
    check("c_restart_retire", retire_count, 32'h0);
    check("c_no_partial", mem[32], 32'hDEAD_BEEF);
    repeat (4) @(negedge clk);
    check("c_store_done", mem[32], 32'h0);
    check("c_retire", retire_count, 32'd1);

    // RV32E instance with non-zero reset PC
    @(negedge clk);
    e_rdata = enc_i(7'h13, 0, 5, 0, 1);
    e_rst = 1'b0;
    #1;
    check("e_first_req", 32'(e_req), 32'h1);
    check("e_first_addr", e_addr, 32'h100);
    repeat (4) @(negedge clk);
    check("e_retire1", e_retire, 32'd1);
    check("e_fetch_104", e_addr, 32'h104);
    e_rdata = enc_i(7'h13, 0, 20, 0, 1);
    repeat (2) @(negedge clk);
    check("e_rd20_trap", 32'(e_trap), 32'h1);
    check("e_trap_req", 32'(e_req), 32'h0);
    check("e_retire_frozen", e_retire, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
